// File: rtl/debounce_pkg.sv
// Shared types for the push-button debouncer: FSM state encoding and counter sizing.
// Reused by any block that needs to interpret the debouncer's state.
package debounce_pkg;

  localparam logic [1:0] ENC_REL    = 2'b00;
  localparam logic [1:0] ENC_WAIT_P = 2'b01;
  localparam logic [1:0] ENC_PRESS  = 2'b10;
  localparam logic [1:0] ENC_WAIT_R = 2'b11;

  typedef enum logic [1:0] {
    REL    = ENC_REL,
    WAIT_P = ENC_WAIT_P,
    PRESS  = ENC_PRESS,
    WAIT_R = ENC_WAIT_R
  } state_t;

  // One spare bit so STABLE_TICKS itself is representable.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks) + 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for one cycle out of every DIV (combinational decode).
// Never restarted except by reset; DIV must be at least 2.
module tick_gen #(
  parameter int DIV = 12000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_count;

  assign tick = (r_count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/debounce.sv
// Push-button debouncer: 2-flop sync, tick-sampled stability FSM, registered level/rise(/fall).
// Commit after STABLE_TICKS agreeing ticks; fall pulse exists only with DEBOUNCE_FALL_PULSE_EN.
module debounce
  import debounce_pkg::*;
#(
  parameter int TICK_DIV      = 12000,
  parameter int STABLE_TICKS  = 10,
  parameter bit ACTIVE_LOW_IN = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
`ifdef DEBOUNCE_FALL_PULSE_EN
  ,
  output logic fall
`endif
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_TICKS - 1);

  logic [1:0]    r_sync;
  logic          w_s;
  logic          w_tick;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic          r_fall;
`endif

  // Synchroniser resets to the idle pin level so reset release never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {2{ACTIVE_LOW_IN}};
    end else begin
      r_sync <= {r_sync[0], btn_raw};
    end
  end

  assign w_s = r_sync[1] ^ ACTIVE_LOW_IN;

  tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= REL;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
      r_fall  <= 1'b0;
`endif
    end else begin
      r_rise <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
      r_fall <= 1'b0;
`endif
      case (r_state)
        REL: begin
          r_cnt <= '0;
          if (w_tick && w_s) begin
            if (STABLE_TICKS == 1) begin
              r_state <= PRESS;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
            end else begin
              r_state <= WAIT_P;
              r_cnt   <= CW'(1);
            end
          end
        end
        WAIT_P: begin
          if (!w_s) begin
            r_state <= REL;
            r_cnt   <= '0;
          end else if (w_tick) begin
            if (r_cnt == LAST_CNT) begin
              r_state <= PRESS;
              r_cnt   <= '0;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        PRESS: begin
          r_cnt <= '0;
          if (w_tick && !w_s) begin
            if (STABLE_TICKS == 1) begin
              r_state <= REL;
              r_level <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
              r_fall  <= 1'b1;
`endif
            end else begin
              r_state <= WAIT_R;
              r_cnt   <= CW'(1);
            end
          end
        end
        WAIT_R: begin
          if (w_s) begin
            r_state <= PRESS;
            r_cnt   <= '0;
          end else if (w_tick) begin
            if (r_cnt == LAST_CNT) begin
              r_state <= REL;
              r_cnt   <= '0;
              r_level <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
              r_fall  <= 1'b1;
`endif
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= REL;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
`ifdef DEBOUNCE_FALL_PULSE_EN
  assign fall  = r_fall;
`endif

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce with TICK_DIV=4, STABLE_TICKS=3, active-low pin.
// Table rows hold the pin for N cycles and check level plus pulse counts; corner cases are hand-written.
module tb_debounce;
  import debounce_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_raw;
  logic level;
  logic rise;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic fall;
`endif

  always #5 clk = ~clk;

  debounce #(
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .ACTIVE_LOW_IN(1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .level  (level),
    .rise   (rise)
`ifdef DEBOUNCE_FALL_PULSE_EN
    ,
    .fall   (fall)
`endif
  );

  typedef struct {
    string name;
    logic  btn;
    int    cyc;
    logic  exp_level;
    int    exp_rise;
    int    exp_fall;
  } vec_t;

  vec_t tbl [14];

  int checks = 0;
  int errors = 0;
  int n_rise, n_fall, n_bad, first_rise;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_rise = 0; n_fall = 0; n_bad = 0; first_rise = -1;
  endtask

  // Samples outputs on falling edges, counting pulses and illegal combinations.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rise) begin
        n_rise++;
        if (first_rise < 0) first_rise = i + 1;
        if (!level) n_bad++;
      end
`ifdef DEBOUNCE_FALL_PULSE_EN
      if (fall) begin
        n_fall++;
        if (level) n_bad++;
      end
      if (rise && fall) n_bad++;
`endif
    end
  endtask

  initial begin
    int lat;
    int w;

    tbl[0]  = '{"press_hold",     1'b0, 40,  1'b1, 0, 0};
    tbl[1]  = '{"rel_glitch_on",  1'b1, 6,   1'b1, 0, 0};
    tbl[2]  = '{"rel_glitch_off", 1'b0, 20,  1'b1, 0, 0};
    tbl[3]  = '{"release",        1'b1, 40,  1'b0, 0, 1};
    tbl[4]  = '{"glitch_on",      1'b0, 6,   1'b0, 0, 0};
    tbl[5]  = '{"glitch_off",     1'b1, 20,  1'b0, 0, 0};
    tbl[6]  = '{"bounce_0a",      1'b0, 3,   1'b0, 0, 0};
    tbl[7]  = '{"bounce_1a",      1'b1, 3,   1'b0, 0, 0};
    tbl[8]  = '{"bounce_0b",      1'b0, 3,   1'b0, 0, 0};
    tbl[9]  = '{"bounce_1b",      1'b1, 3,   1'b0, 0, 0};
    tbl[10] = '{"bounce_settle",  1'b0, 40,  1'b1, 1, 0};
    tbl[11] = '{"short_release",  1'b1, 2,   1'b1, 0, 0};
    tbl[12] = '{"long_hold",      1'b0, 100, 1'b1, 0, 0};
    tbl[13] = '{"final_release",  1'b1, 40,  1'b0, 0, 1};

    // Reset held with the pin released.
    reset_n = 1'b0;
    btn_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_level", int'(level), 0);
      check("reset_rise", int'(rise), 0);
    end
    check("reset_state", int'(dut.r_state), int'(REL));
    reset_n = 1'b1;
    clear_counts();
    run(10);
    check("idle_level", int'(level), 0);
    check("idle_rise_count", n_rise, 0);

    // First press: commit latency from the pin edge.
    btn_raw = 1'b0;
    clear_counts();
    lat = 0;
    while (!level && lat < 30) begin
      @(negedge clk);
      lat++;
      if (rise) n_rise++;
    end
    check("press_latency_11_to_14", int'(lat >= 11 && lat <= 14), 1);
    check("press_rise_with_level", n_rise, 1);

    for (int r = 0; r < 14; r++) begin
      btn_raw = tbl[r].btn;
      clear_counts();
      run(tbl[r].cyc);
      check({tbl[r].name, "_level"}, int'(level), int'(tbl[r].exp_level));
      check({tbl[r].name, "_rise_count"}, n_rise, tbl[r].exp_rise);
`ifdef DEBOUNCE_FALL_PULSE_EN
      check({tbl[r].name, "_fall_count"}, n_fall, tbl[r].exp_fall);
`endif
      check({tbl[r].name, "_illegal_pulse"}, n_bad, 0);
      if (tbl[r].exp_rise > 0)
        check({tbl[r].name, "_rise_latency_ok"},
              int'(first_rise >= 11 && first_rise <= 14), 1);
    end

    // Reset in the middle of a press debounce.
    btn_raw = 1'b0;
    w = 0;
    while (dut.r_state != WAIT_P && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("reach_wait_p", int'(dut.r_state == WAIT_P), 1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_state", int'(dut.r_state), int'(REL));
    check("midreset_cnt", int'(dut.r_cnt), 0);
    check("midreset_level", int'(level), 0);
    clear_counts();
    run(3);
    check("midreset_rise_count", n_rise, 0);
    reset_n = 1'b1;
    clear_counts();
    run(11);
    check("restart_level_early", int'(level), 0);
    check("restart_no_release_pulse", n_rise, 0);
    run(1);
    check("restart_level_at_12", int'(level), 1);
    check("restart_rise_at_12", int'(rise), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
